// File: rtl/sensor_write_sequencer_pkg.sv
// Shared types and default constants for the sensor write sequencer.
package sensor_write_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PENDING = 2'd2
  } seq_state_t;

  localparam int             DEF_SAMPLE_DIV = 500;
  localparam int             DEF_AVG_LOG2   = 2;
  localparam logic [4:0]     DEF_DEST_REG   = 5'd9;
  localparam int             DEF_MAX_WAIT   = 4;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_write_sequencer_tick_gen.sv
// Free-running sample tick divider; held at zero while disabled.
module sample_tick_gen
  import sensor_write_sequencer_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = cnt_width(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/sensor_write_sequencer.sv
// Averages ADC samples and writes each result into the register file,
// sharing the write port with the processor under a bounded-wait arbiter.
module sensor_write_sequencer
  import sensor_write_sequencer_pkg::*;
#(
  parameter int         SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int         AVG_LOG2   = DEF_AVG_LOG2,
  parameter logic [4:0] DEST_REG   = DEF_DEST_REG,
  parameter int         MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        enable,
  input  logic [7:0]  adc_in,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        cpu_stall,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int ACC_W  = 8 + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int WAIT_W = cnt_width(MAX_WAIT + 1);

  seq_state_t        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        pending;
  logic [WAIT_W-1:0] wait_cnt;

  logic              tick;
  logic              in_pending;
  logic              forced;
  logic              seq_write;
  logic              window_done;
  logic [ACC_W-1:0]  acc_final;

  // Truncating mean: the accumulator is wide enough that no sum overflows.
  function automatic logic [7:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return 8'(sum >> AVG_LOG2);
  endfunction

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .enable     (enable),
    .tick       (tick)
  );

  assign acc_final   = acc + ACC_W'(adc_in);
  assign window_done = tick && (cnt == CNT_W'(AVG_N - 1));
  assign in_pending  = (state == ST_PENDING);
  assign forced      = in_pending && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign seq_write   = in_pending && (!cpu_we || forced);
  assign cpu_stall   = forced && cpu_we;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (cpu_we && !forced) begin
      rf_we    = 1'b1;
      rf_waddr = cpu_waddr;
      rf_wdata = cpu_wdata;
    end else if (seq_write) begin
      rf_we    = 1'b1;
      rf_waddr = DEST_REG;
      rf_wdata = {24'b0, pending};
    end
  end

  // A write on the port this cycle still completes when enable drops.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      cnt          <= '0;
      pending      <= '0;
      wait_cnt     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= seq_write;
      if (!enable) begin
        state    <= ST_IDLE;
        acc      <= '0;
        cnt      <= '0;
        pending  <= '0;
        wait_cnt <= '0;
      end else begin
        if (tick) begin
          if (window_done) begin
            acc     <= '0;
            cnt     <= '0;
            pending <= avg_trunc(acc_final);
          end else begin
            acc <= acc_final;
            cnt <= cnt + 1'b1;
          end
        end

        if (seq_write) begin
          wait_cnt <= '0;
        end else if (in_pending && cpu_we) begin
          wait_cnt <= wait_cnt + 1'b1;
        end

        // A result replacing one that never reached the port is an overrun.
        if (window_done) begin
          state <= ST_PENDING;
          if (in_pending && !seq_write) begin
            overrun <= 1'b1;
          end
        end else if (seq_write || state == ST_IDLE) begin
          state <= ST_COLLECT;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_write_sequencer.sv
// Randomized and directed bench for sensor_write_sequencer against a sample-queue reference model.
module tb_sensor_write_sequencer;

  localparam int         SD = 4;
  localparam int         LG = 2;
  localparam int         NS = 1 << LG;
  localparam int         MW = 4;
  localparam logic [4:0] DR = 5'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, cwe = 1'b0;
  logic [7:0]  adc = '0;
  logic [4:0]  cwa = '0;
  logic [31:0] cwd = '0;
  logic        rf_we, stall, sv, ovr;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic        en1 = 1'b0, cwe1 = 1'b0;
  logic [7:0]  adc1 = '0;
  logic [4:0]  cwa1 = '0;
  logic [31:0] cwd1 = '0;
  logic        rf_we1, stall1, sv1, ovr1;
  logic [4:0]  rf_wa1;
  logic [31:0] rf_wd1;

  always #5 clk = ~clk;

  sensor_write_sequencer #(
    .SAMPLE_DIV(SD), .AVG_LOG2(LG), .DEST_REG(DR), .MAX_WAIT(MW)
  ) dut (
    .clock(clk), .ctrl_reset(rst), .enable(en), .adc_in(adc),
    .cpu_we(cwe), .cpu_waddr(cwa), .cpu_wdata(cwd),
    .rf_we(rf_we), .rf_waddr(rf_wa), .rf_wdata(rf_wd),
    .cpu_stall(stall), .sample_valid(sv), .overrun(ovr)
  );

  sensor_write_sequencer #(
    .SAMPLE_DIV(1), .AVG_LOG2(0), .DEST_REG(DR), .MAX_WAIT(MW)
  ) dut1 (
    .clock(clk), .ctrl_reset(rst), .enable(en1), .adc_in(adc1),
    .cpu_we(cwe1), .cpu_waddr(cwa1), .cpu_wdata(cwd1),
    .rf_we(rf_we1), .rf_waddr(rf_wa1), .rf_wdata(rf_wd1),
    .cpu_stall(stall1), .sample_valid(sv1), .overrun(ovr1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: pending result, sample window as a queue, wait count.
  int  phase;
  int  samples[$];
  bit  pv;
  int  pval;
  int  wcnt;
  bit  ovr_m;
  bit  sv_m;

  logic        o_we, o_stall;
  logic [4:0]  o_wa;
  logic [31:0] o_wd;

  function automatic void model_reset();
    phase = 0; samples.delete(); pv = 0; pval = 0; wcnt = 0; ovr_m = 0; sv_m = 0;
  endfunction

  task automatic step(input bit r, input bit e, input logic [7:0] a, input bit we,
                      input logic [4:0] wa, input logic [31:0] wd);
    bit forced, sw, tk;
    int sum;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    @(negedge clk);
    rst = r; en = e; adc = a; cwe = we; cwa = wa; cwd = wd;
    #1;
    if (r) model_reset();
    forced = pv && (wcnt == MW);
    sw     = pv && (!we || forced);
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (we && !forced) begin
      e_we = 1'b1; e_wa = wa; e_wd = wd;
    end else if (sw) begin
      e_we = 1'b1; e_wa = DR; e_wd = 32'(pval);
    end
    check_val("rf_we", rf_we, e_we);
    check_val("rf_waddr", rf_wa, e_wa);
    check_val("rf_wdata", rf_wd, e_wd);
    check_val("cpu_stall", stall, forced && we);
    check_val("sample_valid", sv, sv_m);
    check_val("overrun", ovr, ovr_m);
    o_we = rf_we; o_wa = rf_wa; o_wd = rf_wd; o_stall = stall;
    if (!r) begin
      sv_m = sw;
      if (!e) begin
        phase = 0; samples.delete(); pv = 0; wcnt = 0;
      end else begin
        tk    = (phase == SD - 1);
        phase = tk ? 0 : phase + 1;
        if (sw) begin
          pv = 0; wcnt = 0;
        end else if (pv && we) begin
          wcnt++;
        end
        if (tk) begin
          samples.push_back(int'(a));
          if (samples.size() == NS) begin
            sum = 0;
            foreach (samples[i]) sum += samples[i];
            if (pv) ovr_m = 1;
            pval = sum / NS;
            pv   = 1;
            samples.delete();
          end
        end
      end
    end
  endtask

  task automatic run_to_pending(input string tag);
    int guard = 0;
    while (!pv && guard < 64) begin
      step(0, 1, 8'($urandom), 0, 0, 0);
      guard++;
    end
    check_val(tag, pv, 1);
  endtask

  logic [7:0] tbl029 [4] = '{8'h10, 8'h20, 8'h30, 8'h41};
  logic [7:0] tbl_old[4] = '{8'hF0, 8'hE0, 8'hD0, 8'hC0};
  logic [7:0] tbl_new[4] = '{8'h04, 8'h08, 8'h0C, 8'h11};

  initial begin
    int n_wr, first_wr, seq_wr;
    logic [31:0] seen;
    model_reset();

    // Reset state, with reset asserted between edges
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 8'hFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Constant 0x80 input: one sequencer write every 16 cycles
    n_wr = 0; first_wr = -1; seen = '0;
    for (int i = 0; i < 50; i++) begin
      step(0, 1, 8'h80, 0, 0, 0);
      if (o_we && o_wa == DR) begin
        n_wr++;
        if (first_wr < 0) first_wr = i;
        seen = o_wd;
      end
    end
    check_val("req028_count", n_wr, 3);
    check_val("req028_first", first_wr, 16);
    check_val("req028_data", seen, 32'h80);

    // Truncating average of 0x10,0x20,0x30,0x41
    step(0, 0, 0, 0, 0, 0);
    seen = '0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, (i < 16) ? tbl029[i / 4] : 8'h00, 0, 0, 0);
      if (o_we && o_wa == DR) seen = o_wd;
    end
    check_val("req029_data", seen, 32'h28);

    // Bounded wait: four CPU wins, forced write, then CPU again
    run_to_pending("req030_reach");
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 8'($urandom), 1, 5'd3, $urandom);
      check_val($sformatf("req030_addr%0d", k), o_wa, (k == 4) ? DR : 5'd3);
      check_val($sformatf("req030_stall%0d", k), o_stall, (k == 4));
    end

    // Reset after two ticks of a window, then a fresh window
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, tbl_old[i / 4], 0, 0, 0);
    step(1, 1, 8'hAA, 0, 0, 0);
    step(1, 1, 8'hAA, 0, 0, 0);
    seen = '0; seq_wr = 0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, (i < 16) ? tbl_new[i / 4] : 8'h00, 0, 0, 0);
      if (o_we && o_wa == DR) begin
        seq_wr++;
        seen = o_wd;
      end
    end
    check_val("req032_rst_count", seq_wr, 1);
    check_val("req032_rst_data", seen, 32'h0A);

    // Enable dropped while pending, CPU holding the port that cycle
    run_to_pending("req032_reach");
    step(0, 0, 0, 1, 5'd2, 32'h1234);
    seq_wr = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_we) seq_wr++;
    end
    check_val("req032_en_nowrite", seq_wr, 0);
    seen = '0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, (i < 16) ? tbl_new[3 - i / 4] : 8'h00, 0, 0, 0);
      if (o_we && o_wa == DR) seen = o_wd;
    end
    check_val("req032_en_data", seen, 32'h0A);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0), 8'($urandom),
           ($urandom_range(0, 9) < 4), 5'($urandom), $urandom);
    end
    step(0, 0, 0, 0, 0, 0);

    // Single-sample windows with CPU holding the port: overrun and latest value
    @(negedge clk);
    #1 check_val("req031_ovr_init", ovr1, 0);
    en1 = 1'b1; cwe1 = 1'b1; cwa1 = 5'd4; cwd1 = 32'hCAFE; adc1 = 8'h11;
    @(negedge clk); adc1 = 8'h22;
    @(negedge clk); adc1 = 8'h33;
    @(negedge clk); adc1 = 8'h44;
    #1 check_val("req031_cpu_pass", rf_wa1, 5'd4);
    @(negedge clk); cwe1 = 1'b0; adc1 = 8'h55;
    #1;
    check_val("req031_we", rf_we1, 1);
    check_val("req031_addr", rf_wa1, DR);
    check_val("req031_data", rf_wd1, 32'h44);
    check_val("req031_ovr", ovr1, 1);
    @(negedge clk); en1 = 1'b0;
    #1 check_val("req031_sv", sv1, 1);
    @(negedge clk);
    #1 check_val("req031_ovr_sticky", ovr1, 1);
    check_val("req031_stall", stall1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
